serial_width_adapter: RTL
=========================

// Module: serial_width_adapter
// PURPOSE
//  Bridges the 32-bit host serial word stream (SimSerial serial_in/serial_out) to a narrow
//  off-chip serial link. Direction TX: wide words in, split into NARROW_W beats, LSB beat
//  first. Direction RX: narrow beats in, assembled into wide words, LSB beat first.
//  Sits directly between the SimSerial bridge and the narrow serial pins of the test harness.
// PARAMETERS
//  WIDE_W    32  wide-side word width; must be an integer multiple of NARROW_W
//  NARROW_W   4  narrow-side beat width; BEATS = WIDE_W/NARROW_W, must be >= 2
// PORTS
//  clock           in   1         single clock, all state updates on posedge
//  reset           in   1         synchronous, active-high
//  wide_in_valid   in   1         TX word valid (from SimSerial serial_in_valid)
//  wide_in_ready   out  1         TX word accepted when valid&ready
//  wide_in_bits    in   WIDE_W    TX word
//  narrow_out_valid out 1         TX beat valid
//  narrow_out_ready in  1         TX beat consumed when valid&ready
//  narrow_out_bits out  NARROW_W  TX beat
//  narrow_in_valid in   1         RX beat valid
//  narrow_in_ready out  1         RX beat accepted when valid&ready
//  narrow_in_bits  in   NARROW_W  RX beat
//  wide_out_valid  out  1         RX word valid (to SimSerial serial_out_valid)
//  wide_out_ready  in   1         RX word consumed when valid&ready
//  wide_out_bits   out  WIDE_W    RX word
//  tx_words        out  32        count of TX words fully sent (last beat fired); wraps
//  rx_words        out  32        count of RX words delivered on wide_out; wraps
// BEHAVIOUR
//  Reset (sync, high): tx_busy=0, tx_cnt=0, rx_cnt=0, out_valid=0, both counters=0.
//   During/after reset cycle: wide_in_ready=1, narrow_out_valid=0, narrow_in_ready=1,
//   wide_out_valid=0. Reset mid-word discards partial TX word and partial RX assembly.
//  TX path, states IDLE(tx_busy=0) / SEND(tx_busy=1, tx_cnt in 0..BEATS-1):
//   - narrow_out_valid = tx_busy; narrow_out_bits = tx_word[tx_cnt*NARROW_W +: NARROW_W].
//   - wide_in_ready = !tx_busy | (tx_cnt==BEATS-1 & narrow_out_ready) (full throughput).
//   - wide fire: latch word, tx_busy=1, tx_cnt=0; word visible as beat 0 next cycle.
//   - beat fire, tx_cnt<BEATS-1: tx_cnt++. Last beat fire: tx_words++, and tx_busy=0
//     unless a wide fire occurs the same cycle (then new word loaded, tx_cnt=0, stays SEND).
//   - narrow_out_bits/valid held stable while valid&!ready.
//   - Latency: wide fire at cycle N -> beat 0 valid at N+1; BEATS beats per word, no bubbles
//     when both sides always ready.
//  RX path, assembly reg asm_word + rx_cnt, output reg out_word + out_valid:
//   - Beat fire stores narrow_in_bits into asm_word[rx_cnt*NARROW_W +: NARROW_W], rx_cnt++.
//   - Final beat (rx_cnt==BEATS-1) fire: out_word = {beat, lower asm bits}, out_valid=1,
//     rx_cnt=0; word visible on wide_out next cycle.
//   - narrow_in_ready = !(rx_cnt==BEATS-1 & out_valid & !wide_out_ready): only the final
//     beat stalls, and only when the output slot is occupied and not draining this cycle.
//   - wide fire: out_valid=0 and rx_words++; simultaneous wide fire and final-beat fire
//     loads the new word, out_valid stays 1, rx_words++.
//   - wide_out_bits/valid held stable while valid&!ready.
//  Both paths independent; no interaction other than shared clock/reset.
//  Counters are 32-bit, wrap 0xFFFFFFFF -> 0 without saturation.
// TESTING (WIDE_W=32, NARROW_W=4)
//  1 TX 0x12345678, narrow ready=1 -> beats 8,7,6,5,4,3,2,1 on 8 consecutive cycles; tx_words=1.
//  2 TX back-to-back 0xA5A5A5A5,0x0F0F0F0F, ready=1 -> 16 beats, no gap; wide_in_ready=1 on 8th beat.
//  3 TX with narrow_out_ready toggled 1,0 -> each beat held stable while stalled; order preserved.
//  4 RX beats 1..8, wide_out_ready=0 -> wide_out 0x87654321 valid, held; next 7 beats accepted,
//    8th stalls until wide_out_ready=1, then 2nd word delivered next cycle; rx_words=2.
//  5 Reset asserted after 3 RX beats and 3 TX beats -> all valids 0, counts 0; next 8 RX beats
//    1..8 yield exactly 0x87654321 (no stale nibbles).
//  6 Preload tx_words/rx_words near 0xFFFFFFFF via long run or force -> wraps to 0 cleanly.

Source files
------------

// File: rtl/serial_width_adapter.sv
// serial_width_adapter
//   Bridges a wide serial word stream to a narrow serial link.
//   TX: wide words in, split into NARROW_W beats, LSB beat first.
//   RX: narrow beats in, assembled into wide words, LSB beat first.
// Ports
//   clock, reset                   : single clock, synchronous active-high reset
//   wide_in_valid/ready/bits       : TX word input (WIDE_W)
//   narrow_out_valid/ready/bits    : TX beat output (NARROW_W)
//   narrow_in_valid/ready/bits     : RX beat input (NARROW_W)
//   wide_out_valid/ready/bits      : RX word output (WIDE_W)
//   tx_words, rx_words             : 32-bit wrapping counts of words sent / delivered
module serial_width_adapter #(
  parameter int unsigned WIDE_W   = 32,
  parameter int unsigned NARROW_W = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                wide_in_valid,
  output logic                wide_in_ready,
  input  logic [WIDE_W-1:0]   wide_in_bits,
  output logic                narrow_out_valid,
  input  logic                narrow_out_ready,
  output logic [NARROW_W-1:0] narrow_out_bits,
  input  logic                narrow_in_valid,
  output logic                narrow_in_ready,
  input  logic [NARROW_W-1:0] narrow_in_bits,
  output logic                wide_out_valid,
  input  logic                wide_out_ready,
  output logic [WIDE_W-1:0]   wide_out_bits,
  output logic [31:0]         tx_words,
  output logic [31:0]         rx_words
);

  localparam int unsigned BEATS = WIDE_W / NARROW_W;
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned CTR_W = 32;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  // ---------------- TX path ----------------
  typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;

  tx_state_t                      tx_state, tx_state_nxt;
  logic [CNT_W-1:0]               tx_cnt, tx_cnt_nxt;
  logic [BEATS-1:0][NARROW_W-1:0] tx_word, tx_word_nxt;
  logic [CTR_W-1:0]               tx_words_nxt;
  logic                           tx_last, tx_beat_fire, tx_word_fire;

  // TX next-state: a new word may load in the same cycle the last beat leaves
  always_comb begin
    tx_state_nxt     = tx_state;
    tx_cnt_nxt       = tx_cnt;
    tx_word_nxt      = tx_word;
    tx_words_nxt     = tx_words;
    tx_last          = (tx_cnt == LAST_BEAT);
    narrow_out_valid = (tx_state == TX_SEND);
    narrow_out_bits  = tx_word[tx_cnt];
    tx_beat_fire     = narrow_out_valid & narrow_out_ready;
    wide_in_ready    = !narrow_out_valid | (tx_last & narrow_out_ready);
    tx_word_fire     = wide_in_valid & wide_in_ready;
    case (tx_state)
      TX_IDLE: begin
        if (tx_word_fire) begin
          tx_state_nxt = TX_SEND;
          tx_cnt_nxt   = '0;
          tx_word_nxt  = wide_in_bits;
        end
      end
      TX_SEND: begin
        if (tx_beat_fire) begin
          if (tx_last) begin
            tx_words_nxt = tx_words + CTR_W'(1);
            if (tx_word_fire) begin
              tx_cnt_nxt  = '0;
              tx_word_nxt = wide_in_bits;
            end else begin
              tx_state_nxt = TX_IDLE;
            end
          end else begin
            tx_cnt_nxt = tx_cnt + CNT_W'(1);
          end
        end
      end
      default: tx_state_nxt = TX_IDLE;
    endcase
  end

  // TX state register
  always_ff @(posedge clock) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_word  <= '0;
      tx_words <= '0;
    end else begin
      tx_state <= tx_state_nxt;
      tx_cnt   <= tx_cnt_nxt;
      tx_word  <= tx_word_nxt;
      tx_words <= tx_words_nxt;
    end
  end

  // ---------------- RX path ----------------
  logic [CNT_W-1:0]               rx_cnt, rx_cnt_nxt;
  logic [BEATS-1:0][NARROW_W-1:0] asm_word, asm_word_nxt;
  logic [WIDE_W-1:0]              out_word, out_word_nxt;
  logic                           out_valid, out_valid_nxt;
  logic [CTR_W-1:0]               rx_words_nxt;
  logic                           rx_last, rx_beat_fire, rx_word_fire;

  // RX next-state: only the final beat stalls, and only if the output slot cannot drain
  always_comb begin
    rx_cnt_nxt      = rx_cnt;
    asm_word_nxt    = asm_word;
    out_word_nxt    = out_word;
    out_valid_nxt   = out_valid;
    rx_words_nxt    = rx_words;
    rx_last         = (rx_cnt == LAST_BEAT);
    rx_word_fire    = out_valid & wide_out_ready;
    narrow_in_ready = !(rx_last & out_valid & !wide_out_ready);
    rx_beat_fire    = narrow_in_valid & narrow_in_ready;
    if (rx_word_fire) begin
      out_valid_nxt = 1'b0;
      rx_words_nxt  = rx_words + CTR_W'(1);
    end
    if (rx_beat_fire) begin
      asm_word_nxt[rx_cnt] = narrow_in_bits;
      if (rx_last) begin
        out_word_nxt  = asm_word_nxt;
        out_valid_nxt = 1'b1;
        rx_cnt_nxt    = '0;
      end else begin
        rx_cnt_nxt = rx_cnt + CNT_W'(1);
      end
    end
  end

  // RX state register
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_cnt    <= '0;
      asm_word  <= '0;
      out_word  <= '0;
      out_valid <= 1'b0;
      rx_words  <= '0;
    end else begin
      rx_cnt    <= rx_cnt_nxt;
      asm_word  <= asm_word_nxt;
      out_word  <= out_word_nxt;
      out_valid <= out_valid_nxt;
      rx_words  <= rx_words_nxt;
    end
  end

  assign wide_out_valid = out_valid;
  assign wide_out_bits  = out_word;

endmodule
